// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg -- shared definitions for the pipelined adder.
//   OP_ADD / OP_SUB : encoding of the in_sub operation select bit
//   flags_t         : result flag bundle {cout, ovf, zero}
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;  // carry out of the MSB (subtract: 1 = no borrow)
        logic ovf;   // signed overflow
        logic zero;  // final result is all zeros
    } flags_t;

endpackage

// File: rtl/adder_pipe_seg.sv
// -----------------------------------------------------------------------------
// adder_pipe_seg -- one W-bit slice of the pipelined carry chain, built from
// a ripple of per-bit full adders.
// Ports:
//   i_a, i_b : slice operands (i_b already inverted for subtract)
//   i_cin    : carry into bit 0 of the slice
//   o_sum    : slice sum
//   o_cout   : carry out of the slice MSB
//   o_cmsb   : carry into the slice MSB (used for signed overflow on the top slice)
// -----------------------------------------------------------------------------
module adder_pipe_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[W];
    assign o_cmsb = w_c[W - 1];

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe -- pipelined add/subtract with valid/ready handshake.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; slice k is
// resolved combinationally in front of pipeline rank k, and the last rank is
// the output register. A beat accepted in cycle n is presented in cycle n+STAGES.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   in_valid/in_ready           : operand handshake (in_ready = pipeline advance)
//   in_a, in_b, in_sub, in_cin  : operands, 0=add/1=subtract, carry-in (add only)
//   out_valid/out_ready         : result handshake
//   out_sum, out_cout, out_ovf, out_zero : registered result and flags
// Build option: define ADDER_PIPE_SAT_EN to clamp out_sum on signed overflow
// (otherwise the sum wraps modulo 2^WIDTH).
// -----------------------------------------------------------------------------
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG_W = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("adder_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end
    if (WIDTH < 4 || WIDTH > 128) begin : g_bad_width
        $error("adder_pipe: WIDTH (%0d) outside 4..128", WIDTH);
    end

    // Pipeline ranks 0..STAGES-2. Operands travel full width; slices already
    // consumed are dead and trimmed by synthesis. r_s accumulates the
    // resolved low sum bits (zeros above the current slice).
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];

    logic [WIDTH-1:0] r_sum;
    flags_t           r_flags;

    // Inputs to slice k (rank k-1 outputs, or the port inputs for k = 0)
    logic             w_src_vld [STAGES];
    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_s   [STAGES];
    logic             w_src_c   [STAGES];
    logic [SEG_W-1:0] w_seg_s   [STAGES];
    logic             w_seg_c   [STAGES];
    logic             w_seg_cm  [STAGES];
    logic [WIDTH-1:0] w_new_s   [STAGES];

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_fin_sum;
    flags_t           w_fin_flags;

    // Whole pipeline moves together; it only freezes when a result is
    // waiting and the consumer refuses it.
    assign w_adv    = !r_vld[STAGES-1] | out_ready;
    assign in_ready = w_adv;

    // Subtract is a + ~b + 1: invert b and force the carry-in once, at entry,
    // so the operation travels with the beat as plain addition.
    assign w_b0 = (in_sub == OP_ADD) ? in_b : ~in_b;
    assign w_c0 = (in_sub == OP_SUB) ? 1'b1 : in_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign w_src_vld[k] = in_valid;
            assign w_src_a[k]   = in_a;
            assign w_src_b[k]   = w_b0;
            assign w_src_s[k]   = '0;
            assign w_src_c[k]   = w_c0;
        end else begin : g_next
            assign w_src_vld[k] = r_vld[k-1];
            assign w_src_a[k]   = r_a[k-1];
            assign w_src_b[k]   = r_b[k-1];
            assign w_src_s[k]   = r_s[k-1];
            assign w_src_c[k]   = r_c[k-1];
        end

        adder_pipe_seg #(
            .W(SEG_W)
        ) u_seg (
            .i_a   (w_src_a[k][k*SEG_W +: SEG_W]),
            .i_b   (w_src_b[k][k*SEG_W +: SEG_W]),
            .i_cin (w_src_c[k]),
            .o_sum (w_seg_s[k]),
            .o_cout(w_seg_c[k]),
            .o_cmsb(w_seg_cm[k])
        );

        assign w_new_s[k] = w_src_s[k] | (WIDTH'(w_seg_s[k]) << (k * SEG_W));
    end

    // Final slice: flags and optional clamp, feeding the output register.
    assign w_ovf = w_seg_cm[STAGES-1] ^ w_seg_c[STAGES-1];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        w_fin_sum = w_new_s[STAGES-1];
`ifdef ADDER_PIPE_SAT_EN
        // On overflow both operands share a sign; clamp toward that sign.
        if (w_ovf) begin
            w_fin_sum = {w_src_a[STAGES-1][WIDTH-1], {(WIDTH-1){~w_src_a[STAGES-1][WIDTH-1]}}};
        end
`endif
        w_fin_flags.cout = w_seg_c[STAGES-1];
        w_fin_flags.ovf  = w_ovf;
        w_fin_flags.zero = (w_fin_sum == '0);
    end

    // NOTE: only control (valid bits) and the visible outputs are reset; the
    // intermediate datapath is qualified by its valid bit and needs no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_src_vld[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k] <= w_src_a[k];
                r_b[k] <= w_src_b[k];
                r_s[k] <= w_new_s[k];
                r_c[k] <= w_seg_c[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_flags <= '0;
        end else if (w_adv && w_src_vld[STAGES-1]) begin
            r_sum   <= w_fin_sum;
            r_flags <= w_fin_flags;
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_sum   = r_sum;
    assign out_cout  = r_flags.cout;
    assign out_ovf   = r_flags.ovf;
    assign out_zero  = r_flags.zero;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe -- self-checking bench for adder_pipe (WIDTH=32, STAGES=4).
// Expected results come from signed/unsigned integer arithmetic on the
// accepted operands, queued in acceptance order and compared as results leave.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           lat_mode = 1'b0;
    bit           use_ovr = 1'b0;
    exp_t         ovr;
    bit           was_rst = 1'b0;
    bit           hold_chk = 1'b0;
    logic [W+2:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact signed and unsigned integer results.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t            e;
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          sres;
        logic [63:0]     sres_v;
        if (sub) begin
            sres   = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            sres   = sa + sb + longint'(cin);
            e.cout = ((ua + ub + 64'(cin)) >= 64'h1_0000_0000);
        end
        e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        sres_v = sres;
        e.sum  = sres_v[W-1:0];
`ifdef ADDER_PIPE_SAT_EN
        if (e.ovf) e.sum = (sres > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.zero = (e.sum == '0);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // One clock: scoreboard at the falling edge, return 1 ns after the rise.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            was_rst  = 1'b1;
            hold_chk = 1'b0;
        end else begin
            if (was_rst) begin
                check("post_rst_out", {out_valid, out_cout, out_ovf, out_zero, out_sum}, '0);
                check("post_rst_in_ready", in_ready, 1'b1);
                was_rst = 1'b0;
            end
            if (hold_chk) check("stall_hold", {out_cout, out_ovf, out_zero, out_sum}, held);
            hold_chk = out_valid && !out_ready;
            held     = {out_cout, out_ovf, out_zero, out_sum};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {out_cout, out_ovf, out_zero, out_sum},
                          {e.cout, e.ovf, e.zero, e.sum});
                    if (e.lat) check("latency", cyc - e.acc, S);
                end
            end
            if (in_valid && in_ready) begin
                e     = use_ovr ? ovr : model(in_a, in_b, in_sub, in_cin);
                e.acc = cyc;
                e.lat = lat_mode;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Single beat with a literal expected result and an exact latency check.
    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                            input logic cin, input logic [W-1:0] sum, input logic cout,
                            input logic ovf);
        ovr.sum  = sum;
        ovr.cout = cout;
        ovr.ovf  = ovf;
        ovr.zero = (sum == '0);
        use_ovr  = 1'b1;
        lat_mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        tick();
        in_valid = 1'b0;
        use_ovr  = 1'b0;
        drain(20);
        lat_mode = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Directed corner cases
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
`ifdef ADDER_PIPE_SAT_EN
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
`else
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`endif
        directed(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Ten back-to-back beats with out_ready low in cycles 5..8
        begin
            int sent = 0;
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_cin = 1'($urandom);
            for (int i = 0; sent < 10 && i < 60; i++) begin
                out_ready = !(i >= 5 && i <= 8);
                #1;
                check("stream_in_ready", in_ready, !(i >= 5 && i <= 8));
                if (in_ready) sent++;
                tick();
                if (sent < 10) begin
                    in_a = $urandom; in_b = $urandom;
                    in_sub = 1'($urandom); in_cin = 1'($urandom);
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("stream_sent", sent, 10);
            drain(40);
        end

        // Random traffic with random bubbles and back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = rnd_op(); in_b = rnd_op();
            in_sub = 1'($urandom); in_cin = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(40);

        // Reset with three beats in flight: nothing stale may emerge
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_cin = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale", out_valid, 1'b0);
        end
        directed(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits, legal range 4..128.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline segments; WIDTH SHALL be a multiple of STAGES (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands.
REQ-008 SHALL have port in_sub  input  1  0 = add, 1 = subtract.
REQ-009 SHALL have port in_cin  input  1  carry-in (add only).
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_sum  output  WIDTH  result.
REQ-013 SHALL have ports out_cout, out_ovf, out_zero  output  1 each  carry-out of MSB, signed overflow, result == 0.

Function
REQ-014 Add SHALL compute in_a + in_b + in_cin; subtract SHALL compute in_a + ~in_b + 1 with in_cin ignored.
REQ-015 Carry chain SHALL be split into STAGES segments of WIDTH/STAGES bits; segment k resolved in pipeline stage k, carry registered between stages; untouched upper operand bits and lower sum bits travel in skew registers.
REQ-016 Latency SHALL be exactly STAGES cycles from accepting beat to out_valid with out_ready held high; throughput one beat per cycle.
REQ-017 Pipeline SHALL advance iff (!out_valid | out_ready); in_ready SHALL equal that advance term combinationally; whole pipeline freezes otherwise (no beat lost, duplicated or reordered).
REQ-018 Each stage SHALL carry a valid bit; bubbles (in_valid low on accept cycle) SHALL propagate as invalid stages and compress when downstream stalls are absent.
REQ-019 out_cout SHALL be carry out of bit WIDTH-1 (subtract: 1 = no borrow); out_ovf SHALL be carry into MSB XOR carry out of MSB; out_zero SHALL reflect the final out_sum.
REQ-020 Outputs SHALL be registered and stable while out_valid & !out_ready.
REQ-021 in_sub and in_cin SHALL be captured with operands and travel with the beat; changing them mid-flight SHALL not affect beats already accepted.

Reset
REQ-022 On rst_n low at a clk edge, all stage valid bits and out_valid SHALL clear to 0; out_sum, out_cout, out_ovf, out_zero SHALL clear to 0.
REQ-023 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-024 Macro ADDER_PIPE_SAT_EN defined: on signed overflow out_sum SHALL clamp to max positive (0x7FFF_FFFF at WIDTH 32) if operand sign positive, else min negative (0x8000_0000); out_ovf still 1; out_zero from clamped value.
REQ-025 Macro undefined: out_sum SHALL wrap modulo 2^WIDTH; no saturation logic present.

Structure
REQ-026 Shared package adder_pkg SHALL hold the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the flag bundle typedef (cout, ovf, zero).
REQ-027 One sub-module adder_pipe_seg SHALL implement a WIDTH/STAGES-bit segment add with carry-in/out, built from per-bit full adders; adder_pipe instantiates STAGES copies.

Verification (WIDTH=32, STAGES=4)
REQ-028 Add 0xFFFF_FFFF + 0x0000_0001, cin 0, out_ready 1 -> after 4 cycles sum 0, cout 1, ovf 0, zero 1.
REQ-029 Sub 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, ovf 1, cout 1; with ADDER_PIPE_SAT_EN -> sum 0x8000_0000, ovf 1.
REQ-030 Add 0x7FFF_FFFF + 1 -> ovf 1; wrap build sum 0x8000_0000, sat build 0x7FFF_FFFF.
REQ-031 Stream 10 random beats back-to-back, out_ready low cycles 5-8 -> in_ready low same cycles, all 10 results correct, in order, none dropped or duplicated.
REQ-032 Accept 3 beats, pull rst_n low one cycle -> out_valid 0 next cycle, no stale result ever emerges; new beat then completes in 4 cycles.
